// File: rtl/mcu_exec_pkg.sv
// Shared definitions for the MCU execution core: width defaults,
// ALU operation encodings and status flag bit positions.
package mcu_exec_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int FLAG_W_DEF = 4;
    localparam int DIV_W_DEF  = 4;

    localparam logic [3:0] MODE_ADD = 4'h0;  // A + B
    localparam logic [3:0] MODE_SUB = 4'h1;  // A - B
    localparam logic [3:0] MODE_PSA = 4'h2;  // pass A
    localparam logic [3:0] MODE_PSB = 4'h3;  // pass B
    localparam logic [3:0] MODE_AND = 4'h4;  // A & B
    localparam logic [3:0] MODE_OR  = 4'h5;  // A | B
    localparam logic [3:0] MODE_XOR = 4'h6;  // A ^ B
    localparam logic [3:0] MODE_RSB = 4'h7;  // B - A
    localparam logic [3:0] MODE_INC = 4'h8;  // B + 1
    localparam logic [3:0] MODE_DEC = 4'h9;  // B - 1
    localparam logic [3:0] MODE_ROL = 4'hA;  // rotate B left by A[2:0]
    localparam logic [3:0] MODE_ROR = 4'hB;  // rotate B right by A[2:0]
    localparam logic [3:0] MODE_SHL = 4'hC;  // B << 1
    localparam logic [3:0] MODE_SHR = 4'hD;  // B >> 1, logical
    localparam logic [3:0] MODE_ASR = 4'hE;  // B >> 1, arithmetic
    localparam logic [3:0] MODE_NEG = 4'hF;  // -B

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_S = 1;
    localparam int FLAG_O = 0;

endpackage

// File: rtl/mcu_clk_div.sv
// Programmable clock divider: toggles div_clk every (sel+1) enabled cycles.
// Only built when MCU_EXEC_CLKDIV_EN is defined; otherwise div_clk is tied
// low and no registers exist.
module mcu_clk_div
    import mcu_exec_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] sel,
    output logic             div_clk
);

`ifdef MCU_EXEC_CLKDIV_EN
    logic [DIV_W-1:0] cnt;

    // Count enabled cycles; ">=" lets a shrinking sel end the half-period at once
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            div_clk <= 1'b0;
        end else if (!en) begin
            cnt     <= '0;
            div_clk <= 1'b0;
        end else if (cnt >= sel) begin
            cnt     <= '0;
            div_clk <= ~div_clk;
        end else begin
            cnt     <= cnt + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end
`else
    logic unused_div_inputs;

    // Divider not built: inputs are ignored and the output stays low
    assign unused_div_inputs = ^{clk, rst, en, sel};
    assign div_clk           = 1'b0;
`endif

endmodule

// File: rtl/mcu_exec_core.sv
// MCU execution core: PC incrementer, 16-operation combinational ALU with
// Z/C/S/O flags, and an optional clock divider (MCU_EXEC_CLKDIV_EN).
module mcu_exec_core
    import mcu_exec_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FLAG_W = FLAG_W_DEF,
    parameter int DIV_W  = DIV_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pc_in,
    output logic [DATA_W-1:0] pc_inc,
    input  logic              alu_en,
    input  logic [3:0]        alu_mode,
    input  logic [DATA_W-1:0] alu_op1,
    input  logic [DATA_W-1:0] alu_op2,
    input  logic [FLAG_W-1:0] alu_cflags,
    output logic [DATA_W-1:0] alu_out,
    output logic [FLAG_W-1:0] alu_flags,
    input  logic              div_en,
    input  logic [DIV_W-1:0]  div_sel,
    output logic              div_clk
);

    localparam int M = DATA_W - 1;

    logic [DATA_W:0]     wide;
    logic [2*DATA_W-1:0] rot;
    logic [DATA_W-1:0]   res;
    logic                c_new;
    logic                o_new;
    logic [2:0]          amt;

    assign amt = alu_op1[2:0];

    // PC increment wraps naturally at 2^DATA_W
    assign pc_inc = pc_in + {{(DATA_W-1){1'b0}}, 1'b1};

    // ALU result plus carry/borrow and overflow; logic ops keep incoming C/O
    always_comb begin
        wide  = '0;
        rot   = '0;
        res   = '0;
        c_new = alu_cflags[FLAG_C];
        o_new = alu_cflags[FLAG_O];
        unique case (alu_mode)
            MODE_ADD: begin
                wide  = {1'b0, alu_op1} + {1'b0, alu_op2};
                res   = wide[M:0];
                c_new = wide[DATA_W];
                o_new = (alu_op1[M] == alu_op2[M]) && (res[M] != alu_op1[M]);
            end
            MODE_SUB: begin
                wide  = {1'b0, alu_op1} - {1'b0, alu_op2};
                res   = wide[M:0];
                c_new = wide[DATA_W];
                o_new = (alu_op1[M] != alu_op2[M]) && (res[M] != alu_op1[M]);
            end
            MODE_PSA: res = alu_op1;
            MODE_PSB: res = alu_op2;
            MODE_AND: res = alu_op1 & alu_op2;
            MODE_OR:  res = alu_op1 | alu_op2;
            MODE_XOR: res = alu_op1 ^ alu_op2;
            MODE_RSB: begin
                wide  = {1'b0, alu_op2} - {1'b0, alu_op1};
                res   = wide[M:0];
                c_new = wide[DATA_W];
                o_new = (alu_op2[M] != alu_op1[M]) && (res[M] != alu_op2[M]);
            end
            MODE_INC: begin
                wide  = {1'b0, alu_op2} + {{DATA_W{1'b0}}, 1'b1};
                res   = wide[M:0];
                c_new = wide[DATA_W];
                o_new = !alu_op2[M] && res[M];
            end
            MODE_DEC: begin
                wide  = {1'b0, alu_op2} - {{DATA_W{1'b0}}, 1'b1};
                res   = wide[M:0];
                c_new = wide[DATA_W];
                o_new = alu_op2[M] && !res[M];
            end
            MODE_ROL: begin
                rot = {alu_op2, alu_op2} << amt;
                res = rot[2*DATA_W-1:DATA_W];
            end
            MODE_ROR: begin
                rot = {alu_op2, alu_op2} >> amt;
                res = rot[M:0];
            end
            MODE_SHL: begin
                res   = {alu_op2[M-1:0], 1'b0};
                c_new = alu_op2[M];
                o_new = 1'b0;
            end
            MODE_SHR: begin
                res   = {1'b0, alu_op2[M:1]};
                c_new = alu_op2[0];
                o_new = 1'b0;
            end
            MODE_ASR: begin
                res   = {alu_op2[M], alu_op2[M:1]};
                c_new = alu_op2[0];
                o_new = 1'b0;
            end
            MODE_NEG: begin
                wide  = {(DATA_W+1){1'b0}} - {1'b0, alu_op2};
                res   = wide[M:0];
                c_new = wide[DATA_W];
                o_new = alu_op2[M] && res[M];
            end
        endcase
    end

    // Disabled ALU outputs zero and passes the incoming flags through untouched
    always_comb begin
        alu_out   = '0;
        alu_flags = alu_cflags;
        if (alu_en) begin
            alu_out           = res;
            alu_flags[FLAG_Z] = (res == '0);
            alu_flags[FLAG_C] = c_new;
            alu_flags[FLAG_S] = res[M];
            alu_flags[FLAG_O] = o_new;
        end
    end

    mcu_clk_div #(
        .DIV_W (DIV_W)
    ) u_clk_div (
        .clk     (clk),
        .rst     (rst),
        .en      (div_en),
        .sel     (div_sel),
        .div_clk (div_clk)
    );

endmodule

// File: tb/tb_mcu_exec_core.sv
// Self-checking bench for mcu_exec_core: directed ALU/PC cases, randomized
// ALU sweep against an arithmetic reference model, and divider timing.
module tb_mcu_exec_core;

`ifdef MCU_EXEC_CLKDIV_EN
    localparam bit HAS_DIV = 1'b1;
`else
    localparam bit HAS_DIV = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] pc_in;
    logic [7:0] pc_inc;
    logic       alu_en;
    logic [3:0] alu_mode;
    logic [7:0] alu_op1;
    logic [7:0] alu_op2;
    logic [3:0] alu_cflags;
    logic [7:0] alu_out;
    logic [3:0] alu_flags;
    logic       div_en;
    logic [3:0] div_sel;
    logic       div_clk;

    int tests = 0;
    int fails = 0;

    mcu_exec_core #(
        .DATA_W (8),
        .FLAG_W (4),
        .DIV_W  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .pc_inc     (pc_inc),
        .alu_en     (alu_en),
        .alu_mode   (alu_mode),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_cflags (alu_cflags),
        .alu_out    (alu_out),
        .alu_flags  (alu_flags),
        .div_en     (div_en),
        .div_sel    (div_sel),
        .div_clk    (div_clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Divider output expected only when the divider is built
    function automatic logic dexp(input logic v);
        return HAS_DIV ? v : 1'b0;
    endfunction

    // Reference ALU from arithmetic definitions; returns {flags, result}
    function automatic logic [11:0] ref_alu(input bit en, input int mode, input int a,
                                            input int b, input logic [3:0] cf);
        int  r, sa, sb, sr, amt;
        bit  c, o, z, s;
        logic [7:0] r8;
        c = cf[2];
        o = cf[0];
        if (!en) return {cf, 8'h00};
        sa  = (a > 127) ? a - 256 : a;
        sb  = (b > 127) ? b - 256 : b;
        amt = a % 8;
        r   = 0;
        case (mode)
            0:  begin r = a + b; c = (r > 255); sr = sa + sb; o = (sr > 127) || (sr < -128); end
            1:  begin r = a - b; c = (a < b);   sr = sa - sb; o = (sr > 127) || (sr < -128); end
            2:  r = a;
            3:  r = b;
            4:  r = a & b;
            5:  r = a | b;
            6:  r = a ^ b;
            7:  begin r = b - a; c = (b < a);   sr = sb - sa; o = (sr > 127) || (sr < -128); end
            8:  begin r = b + 1; c = (r > 255); sr = sb + 1;  o = (sr > 127); end
            9:  begin r = b - 1; c = (b == 0);  sr = sb - 1;  o = (sr < -128); end
            10: r = (b << amt) | (b >> (8 - amt));
            11: r = (b >> amt) | (b << (8 - amt));
            12: begin r = b * 2; c = (b >= 128); o = 1'b0; end
            13: begin r = b / 2; c = b[0];       o = 1'b0; end
            14: begin r = sb >>> 1; c = b[0];    o = 1'b0; end
            default: begin r = 0 - b; c = (b != 0); sr = -sb; o = (sr > 127); end
        endcase
        r  = r & 255;
        r8 = r[7:0];
        z  = (r8 == 8'h00);
        s  = r8[7];
        return {z, c, s, o, r8};
    endfunction

    task automatic alu_set(input bit en, input logic [3:0] mode, input logic [7:0] a,
                           input logic [7:0] b, input logic [3:0] cf);
        alu_en     = en;
        alu_mode   = mode;
        alu_op1    = a;
        alu_op2    = b;
        alu_cflags = cf;
        #1;
    endtask

    initial begin
        logic [11:0] exp;
        rst        = 1'b1;
        pc_in      = 8'h00;
        div_en     = 1'b1;
        div_sel    = 4'd2;
        alu_set(1'b0, 4'h0, 8'h00, 8'h00, 4'h0);

        repeat (2) @(posedge clk);
        #1;
        check("rst_div_clk", {31'd0, div_clk}, 32'd0);

        // PC increment
        pc_in = 8'hFF; #1;
        check("pc_wrap", {24'd0, pc_inc}, 32'h00);
        pc_in = 8'h12; #1;
        check("pc_inc", {24'd0, pc_inc}, 32'h13);

        // Directed ALU cases
        alu_set(1'b1, 4'h0, 8'h7F, 8'h01, 4'h0);
        check("add_out", {24'd0, alu_out}, 32'h80);
        check("add_flags", {28'd0, alu_flags}, 32'h3);
        alu_set(1'b1, 4'h1, 8'h05, 8'h05, 4'h0);
        check("sub_zero_out", {24'd0, alu_out}, 32'h00);
        check("sub_zero_flags", {28'd0, alu_flags}, 32'h8);
        alu_set(1'b1, 4'h1, 8'h00, 8'h01, 4'h0);
        check("sub_borrow_out", {24'd0, alu_out}, 32'hFF);
        check("sub_borrow_flags", {28'd0, alu_flags}, 32'h6);
        alu_set(1'b1, 4'hA, 8'h03, 8'h81, 4'h0);
        check("rol_out", {24'd0, alu_out}, 32'h0C);
        check("rol_flags", {28'd0, alu_flags}, 32'h0);
        alu_set(1'b0, 4'hA, 8'h03, 8'h81, 4'hA);
        check("dis_out", {24'd0, alu_out}, 32'h00);
        check("dis_flags", {28'd0, alu_flags}, 32'hA);

        // Every mode with boundary operands, then randomized sweep
        for (int m = 0; m < 16; m++) begin
            alu_set(1'b1, m[3:0], 8'h80, 8'h7F, 4'h5);
            exp = ref_alu(1'b1, m, 8'h80, 8'h7F, 4'h5);
            check($sformatf("edge1_m%0h", m), {20'd0, alu_flags, alu_out}, {20'd0, exp});
            alu_set(1'b1, m[3:0], 8'hFF, 8'h80, 4'hA);
            exp = ref_alu(1'b1, m, 8'hFF, 8'h80, 4'hA);
            check($sformatf("edge2_m%0h", m), {20'd0, alu_flags, alu_out}, {20'd0, exp});
            alu_set(1'b1, m[3:0], 8'h07, 8'h00, 4'hF);
            exp = ref_alu(1'b1, m, 8'h07, 8'h00, 4'hF);
            check($sformatf("edge3_m%0h", m), {20'd0, alu_flags, alu_out}, {20'd0, exp});
        end
        for (int i = 0; i < 300; i++) begin
            int          m, a, b;
            bit          en;
            logic [3:0]  cf;
            logic [7:0]  pc;
            m  = int'($urandom_range(0, 15));
            a  = int'($urandom_range(0, 255));
            b  = int'($urandom_range(0, 255));
            en = ($urandom_range(0, 7) != 0);
            cf = 4'($urandom);
            pc = 8'($urandom);
            pc_in = pc;
            alu_set(en, m[3:0], a[7:0], b[7:0], cf);
            exp = ref_alu(en, m, a, b, cf);
            check($sformatf("rnd_m%0h_a%0h_b%0h", m, a, b),
                  {20'd0, alu_flags, alu_out}, {20'd0, exp});
            check("rnd_pc", {24'd0, pc_inc}, 32'((int'(pc) + 1) % 256));
        end

        // Divider: sel=2 gives toggles every 3 edges after reset release
        @(negedge clk);
        rst     = 1'b0;
        div_en  = 1'b1;
        div_sel = 4'd2;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk); #1;
            check($sformatf("div3_n%0d", n), {31'd0, div_clk}, {31'd0, dexp(1'((n / 3) % 2))});
        end
        @(negedge clk);
        div_en = 1'b0;
        @(posedge clk); #1;
        check("div_drop", {31'd0, div_clk}, 32'd0);
        @(posedge clk); #1;
        check("div_drop_hold", {31'd0, div_clk}, 32'd0);

        // sel=0 gives clk/2
        @(negedge clk);
        div_en  = 1'b1;
        div_sel = 4'd0;
        for (int n = 1; n <= 9; n++) begin
            @(posedge clk); #1;
            check($sformatf("div1_n%0d", n), {31'd0, div_clk}, {31'd0, dexp(1'(n % 2))});
        end

        // Reset while enabled forces low on the next edge
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("div_rst", {31'd0, div_clk}, 32'd0);

        // Shrinking sel mid-count toggles on the next edge and restarts
        @(negedge clk);
        rst     = 1'b0;
        div_sel = 4'd5;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk); #1;
            check($sformatf("div6_n%0d", n), {31'd0, div_clk}, 32'd0);
        end
        @(negedge clk);
        div_sel = 4'd2;
        @(posedge clk); #1;
        check("div_resel", {31'd0, div_clk}, {31'd0, dexp(1'b1)});
        for (int n = 1; n <= 3; n++) begin
            @(posedge clk); #1;
            check($sformatf("div_resel_n%0d", n), {31'd0, div_clk},
                  {31'd0, dexp(n < 3 ? 1'b1 : 1'b0)});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mcu_exec_core.md
MCU_EXEC_CORE -- requirements
Module: mcu_exec_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning datapath, operand and PC width.
REQ-002 SHALL have parameter FLAG_W, default 4, meaning status flag vector width.
REQ-003 SHALL have parameter DIV_W, default 4, meaning divider select width.
REQ-004 SHALL have port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, reset that is synchronous and active-high.
REQ-006 SHALL have port pc_in, input, DATA_W bits, current program counter.
REQ-007 SHALL have port pc_inc, output, DATA_W bits, incremented PC.
REQ-008 SHALL have port alu_en, input, 1 bit, ALU enable.
REQ-009 SHALL have port alu_mode, input, 4 bits, operation select.
REQ-010 SHALL have port alu_op1, input, DATA_W bits, accumulator operand (A).
REQ-011 SHALL have port alu_op2, input, DATA_W bits, data/immediate operand (B).
REQ-012 SHALL have port alu_cflags, input, FLAG_W bits, current flags {Z,C,S,O}.
REQ-013 SHALL have port alu_out, output, DATA_W bits, result.
REQ-014 SHALL have port alu_flags, output, FLAG_W bits, updated flags.
REQ-015 SHALL have port div_en, input, 1 bit, divider enable.
REQ-016 SHALL have port div_sel, input, DIV_W bits, divide select N.
REQ-017 SHALL have port div_clk, output, 1 bit, divided clock.

Function
REQ-018 SHALL drive pc_inc = pc_in + 1 combinationally, modulo 2^DATA_W (0xFF -> 0x00).
REQ-019 SHALL make the ALU combinational, with zero latency.
REQ-020 SHALL, when alu_en=0, drive alu_out=0 and alu_flags=alu_cflags.
REQ-021 SHALL use these alu_mode encodings:
- 0 = A+B
- 1 = A-B
- 2 = A
- 3 = B
- 4 = A&B
- 5 = A|B
- 6 = A^B
- 7 = B-A
- 8 = B+1
- 9 = B-1
- A = rotate-left B by A[2:0]
- B = rotate-right B by A[2:0]
- C = shift-left B by 1
- D = logical shift-right B by 1
- E = arithmetic shift-right B by 1
- F = -B (two's complement)
REQ-022 SHALL set the flags as follows:
- flags[3] Z = (alu_out==0).
- flags[1] S = alu_out MSB.
- flags[2] C = carry-out for add/increment modes.
- flags[2] C = borrow for subtract/decrement/negate modes.
- flags[2] C = bit shifted out for modes C/D/E.
- flags[0] O = signed overflow for add/subtract/increment/decrement/negate modes.
REQ-023 SHALL preserve C and O from alu_cflags for modes 2-6 and A-B, and clear O for modes C-E.
REQ-024 SHALL have the divider hold a counter; when div_en=1 it counts clk cycles and toggles div_clk every (div_sel+1) cycles, giving period 2*(div_sel+1) (div_sel=0 -> clk/2, div_sel=15 -> clk/32).
REQ-025 SHALL, when div_en=0, clear the counter and force div_clk low on the next edge.
REQ-026 SHALL, if div_sel changes mid-count so that counter >= new div_sel, toggle on the next edge and restart the count.

Reset
REQ-027 SHALL, with rst=1 at a clk edge, clear the divider counter and div_clk to 0, with priority over div_en.
REQ-028 SHALL keep the adder and ALU unaffected by rst (pure combinational).

Configuration
REQ-029 SHALL gate the divider with macro MCU_EXEC_CLKDIV_EN:
- Defined: the divider is built as specified.
- Undefined: no divider registers exist, div_clk is tied 0, div_en and div_sel are ignored.

Structure
REQ-030 SHALL place the alu_mode encodings (16 localparams), the flag bit indices (Z=3, C=2, S=1, O=0) and the width defaults in shared package mcu_exec_pkg.
REQ-031 SHALL implement the divider as one sub-module, mcu_clk_div; the adder and ALU remain inline.

Verification
REQ-032 SHALL cover: alu_en=1, mode 0, A=0x7F, B=0x01 -> alu_out=0x80, flags Z0 C0 S1 O1.
REQ-033 SHALL cover: mode 1, A=0x05, B=0x05 -> alu_out=0x00, Z=1, C=0; then mode 1, A=0x00, B=0x01 -> 0xFF, C=1, S=1.
REQ-034 SHALL cover: mode A, A=0x03, B=0x81 -> alu_out=0x0C; then alu_en=0 with cflags=0xA -> alu_out=0x00, flags=0xA.
REQ-035 SHALL cover: pc_in=0xFF -> pc_inc=0x00; pc_in=0x12 -> pc_inc=0x13.
REQ-036 SHALL cover: rst then div_en=1, div_sel=2 -> div_clk toggles every 3 clk cycles (period 6); div_sel=0 -> period 2.
REQ-037 SHALL cover: div_en dropped mid-period -> div_clk=0 next edge; rst asserted while div_en=1 -> div_clk=0 next edge.
